ahb_bus_arbiter: RTL and testbench

Sequences and shares the single external bus master port (PADDR_A…PWDATA_A) between NUM_REQ requesters. Typical requesters are the pipeline's data-memory path and a future instruction-fetch or debug port.
Issues single-beat AHB-style transfers: one address phase, then a data phase that waits on PREADY_A. Returns read data and error status to the winning requester, and times out on an unresponsive slave.

---
 rtl/rv32_bus_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/ahb_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_bus_pkg.sv
// Shared bus encodings and arbiter types for the single-master AHB-style port.
package rv32_bus_pkg;

    localparam logic [1:0] PTRANS_IDLE   = 2'b00;
    localparam logic [1:0] PTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] PBURST_SINGLE = 3'b000;

    localparam logic [1:0] PSIZE_BYTE = 2'b00;
    localparam logic [1:0] PSIZE_HALF = 2'b01;
    localparam logic [1:0] PSIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } arb_state_t;

    // Request captured from the winning requester at grant time.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [1:0]  size;
        logic [31:0] wdata;
    } xfer_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner pick: round-robin from ptr_i, or fixed priority
// (lowest index) when arb_mode_i is set.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               arb_mode_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    int start;
    int cand;

    // NOTE: combinational logic uses blocking '=' so later statements see
    // the values just computed; every output gets a default first so no
    // latch is inferred.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        start   = arb_mode_i ? 0 : int'(ptr_i);
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (start + i) % NUM_REQ;
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Shares one AHB-style master port between NUM_REQ requesters: single-beat
// transfers with address phase, waited data phase and data-phase timeout.
module ahb_bus_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ-1:0][31:0] req_addr_i,
    input  logic [NUM_REQ-1:0]       req_write_i,
    input  logic [NUM_REQ-1:0][1:0]  req_size_i,
    input  logic [NUM_REQ-1:0][31:0] req_wdata_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     err_o,
    output logic [31:0]              rdata_o,
    output logic                     busy_o,
    input  logic [31:0]              PRDATA_A,
    input  logic                     PREADY_A,
    input  logic                     PRESP_A,
    output logic [31:0]              PADDR_A,
    output logic                     PWRITE_A,
    output logic [1:0]               PSIZE_A,
    output logic [1:0]               PTRANS_A,
    output logic [2:0]               PBURST_A,
    output logic [31:0]              PWDATA_A
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t         state_q, state_d;
    xfer_t              owner_q, owner_d;
    logic [IDX_W-1:0]   owner_idx_q, owner_idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic               err_q, err_d, busy_q, busy_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic               pwrite_q, pwrite_d;
    logic [1:0]         psize_q, psize_d, ptrans_q, ptrans_d;

    logic               arb_valid;
    logic [IDX_W-1:0]   arb_idx;
    logic               timeout_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .arb_mode_i (ARB_MODE != 0),
        .req_i      (req_i),
        .ptr_i      (ptr_q),
        .valid_o    (arb_valid),
        .idx_o      (arb_idx)
    );

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = ADDR;
            ADDR:    state_d = DATA;
            DATA:    if (PREADY_A || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d     = owner_q;
        owner_idx_d = owner_idx_q;
        ptr_d       = ptr_q;
        cnt_d       = '0;
        gnt_d       = '0;
        done_d      = '0;
        err_d       = 1'b0;
        rdata_d     = '0;
        ptrans_d    = PTRANS_IDLE;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        psize_d     = psize_q;
        pwdata_d    = pwdata_q;
        busy_d      = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                paddr_d  = '0;
                pwrite_d = 1'b0;
                psize_d  = '0;
                pwdata_d = '0;
                if (arb_valid) begin
                    owner_idx_d = arb_idx;
                    owner_d     = '{addr:  req_addr_i[arb_idx],
                                    write: req_write_i[arb_idx],
                                    size:  req_size_i[arb_idx],
                                    wdata: req_wdata_i[arb_idx]};
                    gnt_d       = NUM_REQ'(1) << arb_idx;
                    ptrans_d    = PTRANS_NONSEQ;
                    paddr_d     = req_addr_i[arb_idx];
                    pwrite_d    = req_write_i[arb_idx];
                    psize_d     = req_size_i[arb_idx];
                    if (ARB_MODE == 0)
                        ptr_d = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
                end
            end
            ADDR: pwdata_d = owner_q.write ? owner_q.wdata : 32'h0;
            DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (PREADY_A || timeout_hit) begin
                    done_d   = NUM_REQ'(1) << owner_idx_q;
                    err_d    = PREADY_A ? PRESP_A : 1'b1;
                    rdata_d  = (PREADY_A && !owner_q.write) ? PRDATA_A : 32'h0;
                    paddr_d  = '0;
                    pwrite_d = 1'b0;
                    psize_d  = '0;
                    pwdata_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= '0;
            owner_idx_q <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            ptrans_q    <= PTRANS_IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            psize_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            owner_q     <= owner_d;
            owner_idx_q <= owner_idx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            ptrans_q    <= ptrans_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            psize_q     <= psize_d;
            pwdata_q    <= pwdata_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;
    assign busy_o   = busy_q;
    assign PADDR_A  = paddr_q;
    assign PWRITE_A = pwrite_q;
    assign PSIZE_A  = psize_q;
    assign PTRANS_A = ptrans_q;
    assign PBURST_A = PBURST_SINGLE;
    assign PWDATA_A = pwdata_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: a round-robin and a fixed-priority instance share
// stimulus; expectations come from a small arbitration/transfer model.
module tb_ahb_bus_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]       req_i;
    logic [N-1:0][31:0] req_addr_i;
    logic [N-1:0]       req_write_i;
    logic [N-1:0][1:0]  req_size_i;
    logic [N-1:0][31:0] req_wdata_i;
    logic [31:0]        PRDATA_A;
    logic               PREADY_A, PRESP_A;

    logic [N-1:0] gnt_o, done_o;
    logic         err_o, busy_o, PWRITE_A;
    logic [31:0]  rdata_o, PADDR_A, PWDATA_A;
    logic [1:0]   PSIZE_A, PTRANS_A;
    logic [2:0]   PBURST_A;

    logic [N-1:0] fp_gnt_o, fp_done_o;
    logic         fp_err_o, fp_busy_o, fp_pwrite;
    logic [31:0]  fp_rdata_o, fp_paddr, fp_pwdata;
    logic [1:0]   fp_psize, fp_ptrans;
    logic [2:0]   fp_pburst;

    ahb_bus_arbiter #(.NUM_REQ(N), .ARB_MODE(0), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_addr_i(req_addr_i),
        .req_write_i(req_write_i), .req_size_i(req_size_i), .req_wdata_i(req_wdata_i),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .PRDATA_A(PRDATA_A), .PREADY_A(PREADY_A), .PRESP_A(PRESP_A),
        .PADDR_A(PADDR_A), .PWRITE_A(PWRITE_A), .PSIZE_A(PSIZE_A), .PTRANS_A(PTRANS_A),
        .PBURST_A(PBURST_A), .PWDATA_A(PWDATA_A)
    );

    ahb_bus_arbiter #(.NUM_REQ(N), .ARB_MODE(1), .TIMEOUT(TO)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_addr_i(req_addr_i),
        .req_write_i(req_write_i), .req_size_i(req_size_i), .req_wdata_i(req_wdata_i),
        .gnt_o(fp_gnt_o), .done_o(fp_done_o), .err_o(fp_err_o), .rdata_o(fp_rdata_o),
        .busy_o(fp_busy_o), .PRDATA_A(PRDATA_A), .PREADY_A(PREADY_A), .PRESP_A(PRESP_A),
        .PADDR_A(fp_paddr), .PWRITE_A(fp_pwrite), .PSIZE_A(fp_psize), .PTRANS_A(fp_ptrans),
        .PBURST_A(fp_pburst), .PWDATA_A(fp_pwdata)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int rr_ptr = 0;

    logic [31:0] a_addr [N];
    logic        a_write[N];
    logic [1:0]  a_size [N];
    logic [31:0] a_wdata[N];

    logic [N-1:0] o_gnt, o_gnt_fp, o_done, o_done_fp;
    logic [1:0]   o_ptrans_addr, o_ptrans_data, o_psize;
    logic [31:0]  o_paddr, o_pwdata, o_rdata;
    logic         o_pwrite, o_busy_addr, o_busy_end, o_err, o_pwdata_stable, o_clean;
    int           o_cycles;

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int i = 0; i < N; i++)
            if (m[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic int fp_pick(input logic [N-1:0] m);
        for (int i = 0; i < N; i++)
            if (m[i]) return i;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [31:0] addr, input logic wr,
                           input logic [1:0] size, input logic [31:0] wdata);
        a_addr[i] = addr; a_write[i] = wr; a_size[i] = size; a_wdata[i] = wdata;
        req_addr_i[i] = addr; req_write_i[i] = wr; req_size_i[i] = size; req_wdata_i[i] = wdata;
    endtask

    // Drives one transfer from an IDLE-cycle negedge; the slave answers after
    // 'waits' low-ready DATA cycles (never, if waits >= TO). Returns at the done negedge.
    task automatic run_xfer(input logic [N-1:0] mask, input bit hold, input int waits,
                            input logic resp, input logic [31:0] rdata);
        req_i = mask;
        PREADY_A = 1'b1;
        PRESP_A  = 1'b1;
        @(negedge clk);
        o_gnt = gnt_o; o_gnt_fp = fp_gnt_o; o_ptrans_addr = PTRANS_A;
        o_paddr = PADDR_A; o_pwrite = PWRITE_A; o_psize = PSIZE_A; o_busy_addr = busy_o;
        if (!hold) req_i = '0;
        @(negedge clk);
        o_ptrans_data = PTRANS_A; o_pwdata = PWDATA_A;
        o_pwdata_stable = 1'b1; o_clean = 1'b1; o_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (PWDATA_A !== o_pwdata) o_pwdata_stable = 1'b0;
            if (done_o !== '0 || err_o !== 1'b0 || rdata_o !== 32'h0) o_clean = 1'b0;
            PREADY_A = (k == waits);
            PRESP_A  = (k == waits) ? resp : 1'($urandom_range(0, 1));
            PRDATA_A = (k == waits) ? rdata : $urandom;
            @(negedge clk);
            if (done_o !== '0 || fp_done_o !== '0) begin
                o_cycles = k + 1;
                break;
            end
        end
        o_done = done_o; o_done_fp = fp_done_o; o_err = err_o;
        o_rdata = rdata_o; o_busy_end = busy_o;
        PREADY_A = 1'b0;
        PRESP_A  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_i = '0; PREADY_A = 1'b0; PRESP_A = 1'b0; PRDATA_A = '0;
        for (int i = 0; i < N; i++) set_req(i, '0, 1'b0, 2'b00, '0);
        repeat (3) @(negedge clk);
        total_cnt++; if ({gnt_o, done_o, err_o, rdata_o, busy_o, PADDR_A, PWRITE_A, PSIZE_A, PTRANS_A, PBURST_A, PWDATA_A} !== '0)
            $display("FAIL reset_outputs: got %h expected 0", {gnt_o, done_o, err_o, rdata_o, busy_o, PADDR_A, PWRITE_A, PSIZE_A, PTRANS_A, PBURST_A, PWDATA_A}); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if ({busy_o, PTRANS_A, gnt_o, done_o} !== '0)
            $display("FAIL idle_after_reset: got %h expected 0", {busy_o, PTRANS_A, gnt_o, done_o}); else pass_cnt++;
        rr_ptr = 0;
    endtask

    task automatic test_single_read();
        int w;
        set_req(0, 32'h0000_1000, 1'b0, 2'b10, 32'h0);
        w = rr_pick(2'b01, rr_ptr); rr_ptr = (w + 1) % N;
        run_xfer(2'b01, 1'b0, 0, 1'b0, 32'hDEAD_BEEF);
        total_cnt++; if (o_gnt !== 2'b01) $display("FAIL rd_gnt: got %b expected 01", o_gnt); else pass_cnt++;
        total_cnt++; if (o_ptrans_addr !== 2'b10) $display("FAIL rd_ptrans_addr: got %b expected 10", o_ptrans_addr); else pass_cnt++;
        total_cnt++; if ({o_paddr, o_pwrite, o_psize} !== {32'h0000_1000, 1'b0, 2'b10})
            $display("FAIL rd_addr_phase: got %h/%b/%b expected 00001000/0/10", o_paddr, o_pwrite, o_psize); else pass_cnt++;
        total_cnt++; if (o_busy_addr !== 1'b1) $display("FAIL rd_busy: got %b expected 1", o_busy_addr); else pass_cnt++;
        total_cnt++; if (o_ptrans_data !== 2'b00) $display("FAIL rd_ptrans_data: got %b expected 00", o_ptrans_data); else pass_cnt++;
        total_cnt++; if (o_cycles !== 1) $display("FAIL rd_latency: got %0d expected 1 data cycle", o_cycles); else pass_cnt++;
        total_cnt++; if (o_done !== 2'b01) $display("FAIL rd_done: got %b expected 01", o_done); else pass_cnt++;
        total_cnt++; if ({o_err, o_rdata} !== {1'b0, 32'hDEAD_BEEF})
            $display("FAIL rd_data: got err=%b rdata=%h expected err=0 rdata=deadbeef", o_err, o_rdata); else pass_cnt++;
        total_cnt++; if (o_busy_end !== 1'b0) $display("FAIL rd_busy_end: got %b expected 0", o_busy_end); else pass_cnt++;
    endtask

    task automatic test_write_wait();
        int w;
        set_req(1, 32'h0000_2004, 1'b1, 2'b10, 32'h1234_5678);
        w = rr_pick(2'b10, rr_ptr); rr_ptr = (w + 1) % N;
        run_xfer(2'b10, 1'b0, 3, 1'b0, 32'hFFFF_FFFF);
        total_cnt++; if (o_gnt !== 2'b10) $display("FAIL wr_gnt: got %b expected 10", o_gnt); else pass_cnt++;
        total_cnt++; if (o_pwrite !== 1'b1) $display("FAIL wr_pwrite: got %b expected 1", o_pwrite); else pass_cnt++;
        total_cnt++; if (o_pwdata !== 32'h1234_5678 || !o_pwdata_stable)
            $display("FAIL wr_pwdata: got %h stable=%b expected 12345678 stable", o_pwdata, o_pwdata_stable); else pass_cnt++;
        total_cnt++; if (o_cycles !== 4) $display("FAIL wr_wait_cycles: got %0d expected 4", o_cycles); else pass_cnt++;
        total_cnt++; if (o_clean !== 1'b1) $display("FAIL wr_early_outputs: got clean=%b expected 1", o_clean); else pass_cnt++;
        total_cnt++; if ({o_done, o_err, o_rdata} !== {2'b10, 1'b0, 32'h0})
            $display("FAIL wr_done: got done=%b err=%b rdata=%h expected 10/0/0", o_done, o_err, o_rdata); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int w;
        set_req(0, 32'h0000_0100, 1'b0, 2'b10, 32'h0);
        set_req(1, 32'h0000_0200, 1'b0, 2'b01, 32'h0);
        for (int t = 0; t < 4; t++) begin
            w = rr_pick(2'b11, rr_ptr); rr_ptr = (w + 1) % N;
            run_xfer(2'b11, 1'b1, 0, 1'b0, 32'hA000_0000 + 32'(t));
            total_cnt++; if (o_gnt !== N'(1 << w) || o_done !== N'(1 << w))
                $display("FAIL rr_order[%0d]: got gnt=%b done=%b expected %b", t, o_gnt, o_done, N'(1 << w)); else pass_cnt++;
            total_cnt++; if (o_gnt_fp !== 2'b01 || o_done_fp !== 2'b01)
                $display("FAIL fp_order[%0d]: got gnt=%b done=%b expected 01", t, o_gnt_fp, o_done_fp); else pass_cnt++;
            total_cnt++; if (o_paddr !== a_addr[w]) $display("FAIL rr_paddr[%0d]: got %h expected %h", t, o_paddr, a_addr[w]); else pass_cnt++;
        end
        req_i = '0;
        @(negedge clk);
    endtask

    task automatic test_slave_error();
        int w;
        set_req(0, 32'h0000_3000, 1'b0, 2'b00, 32'h0);
        w = rr_pick(2'b01, rr_ptr); rr_ptr = (w + 1) % N;
        run_xfer(2'b01, 1'b0, 1, 1'b1, 32'h0BAD_0BAD);
        total_cnt++; if ({o_done, o_err} !== {2'b01, 1'b1})
            $display("FAIL err_resp: got done=%b err=%b expected 01/1", o_done, o_err); else pass_cnt++;
        w = rr_pick(2'b01, rr_ptr); rr_ptr = (w + 1) % N;
        run_xfer(2'b01, 1'b0, 0, 1'b0, 32'h0000_0055);
        total_cnt++; if ({o_done, o_err, o_rdata} !== {2'b01, 1'b0, 32'h55})
            $display("FAIL err_next_clear: got done=%b err=%b rdata=%h expected 01/0/55", o_done, o_err, o_rdata); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int w;
        set_req(1, 32'h0000_4000, 1'b1, 2'b10, 32'hCAFE_F00D);
        w = rr_pick(2'b10, rr_ptr); rr_ptr = (w + 1) % N;
        run_xfer(2'b10, 1'b0, 99, 1'b0, 32'h0);
        total_cnt++; if (o_cycles !== TO) $display("FAIL to_cycles: got %0d expected %0d", o_cycles, TO); else pass_cnt++;
        total_cnt++; if ({o_done, o_err, o_rdata} !== {2'b10, 1'b1, 32'h0})
            $display("FAIL to_done: got done=%b err=%b rdata=%h expected 10/1/0", o_done, o_err, o_rdata); else pass_cnt++;
        total_cnt++; if (o_busy_end !== 1'b0) $display("FAIL to_busy: got %b expected 0", o_busy_end); else pass_cnt++;
    endtask

    task automatic test_reset_mid_data();
        bit seen;
        int w;
        set_req(0, 32'h0000_5000, 1'b0, 2'b10, 32'h0);
        set_req(1, 32'h0000_6000, 1'b1, 2'b10, 32'h7777_0000);
        // Granted to requester 0, so the round-robin pointer now favours 1.
        req_i = 2'b01; PREADY_A = 1'b0;
        @(negedge clk);
        req_i = '0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if ({gnt_o, done_o, err_o, rdata_o, busy_o, PADDR_A, PWRITE_A, PSIZE_A, PTRANS_A, PWDATA_A} !== '0)
            $display("FAIL rst_mid_outputs: got %h expected 0", {gnt_o, done_o, err_o, rdata_o, busy_o, PADDR_A, PWRITE_A, PSIZE_A, PTRANS_A, PWDATA_A}); else pass_cnt++;
        PREADY_A = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done_o !== '0 || busy_o !== 1'b0) seen = 1'b1;
        end
        total_cnt++; if (seen !== 1'b0) $display("FAIL rst_mid_no_done: got activity=%b expected 0", seen); else pass_cnt++;
        PREADY_A = 1'b0;
        rst_n = 1'b1;
        rr_ptr = 0;
        @(negedge clk);
        w = rr_pick(2'b11, rr_ptr); rr_ptr = (w + 1) % N;
        run_xfer(2'b11, 1'b0, 2, 1'b0, 32'h1357_9BDF);
        total_cnt++; if ({o_gnt, o_done, o_err, o_rdata} !== {N'(1 << w), N'(1 << w), 1'b0, 32'h1357_9BDF})
            $display("FAIL rst_mid_recover: got gnt=%b done=%b err=%b rdata=%h expected %b/%b/0/13579bdf",
                     o_gnt, o_done, o_err, o_rdata, N'(1 << w), N'(1 << w)); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        logic [31:0]  rd, exp_rdata, exp_pwdata;
        logic         resp, exp_err;
        int           waits, w, wf, exp_cycles;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++)
                set_req(i, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom);
            mask  = N'($urandom_range(1, (1 << N) - 1));
            waits = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 4);
            resp  = 1'($urandom_range(0, 1));
            rd    = $urandom;
            w  = rr_pick(mask, rr_ptr); rr_ptr = (w + 1) % N;
            wf = fp_pick(mask);
            exp_cycles = (waits >= TO) ? TO : waits + 1;
            exp_err    = (waits >= TO) ? 1'b1 : resp;
            exp_rdata  = (waits >= TO || a_write[w]) ? 32'h0 : rd;
            exp_pwdata = a_write[w] ? a_wdata[w] : 32'h0;
            run_xfer(mask, 1'b0, waits, resp, rd);
            total_cnt++; if (o_gnt !== N'(1 << w) || o_gnt_fp !== N'(1 << wf))
                $display("FAIL rnd_gnt[%0d]: got rr=%b fp=%b expected rr=%b fp=%b", it, o_gnt, o_gnt_fp, N'(1 << w), N'(1 << wf)); else pass_cnt++;
            total_cnt++; if ({o_paddr, o_pwrite, o_psize} !== {a_addr[w], a_write[w], a_size[w]})
                $display("FAIL rnd_addr[%0d]: got %h/%b/%b expected %h/%b/%b", it, o_paddr, o_pwrite, o_psize, a_addr[w], a_write[w], a_size[w]); else pass_cnt++;
            total_cnt++; if (o_pwdata !== exp_pwdata || !o_pwdata_stable)
                $display("FAIL rnd_pwdata[%0d]: got %h stable=%b expected %h", it, o_pwdata, o_pwdata_stable, exp_pwdata); else pass_cnt++;
            total_cnt++; if (o_cycles !== exp_cycles) $display("FAIL rnd_cycles[%0d]: got %0d expected %0d", it, o_cycles, exp_cycles); else pass_cnt++;
            total_cnt++; if (o_done !== N'(1 << w) || o_done_fp !== N'(1 << wf))
                $display("FAIL rnd_done[%0d]: got rr=%b fp=%b expected rr=%b fp=%b", it, o_done, o_done_fp, N'(1 << w), N'(1 << wf)); else pass_cnt++;
            total_cnt++; if ({o_err, o_rdata} !== {exp_err, exp_rdata})
                $display("FAIL rnd_resp[%0d]: got err=%b rdata=%h expected err=%b rdata=%h", it, o_err, o_rdata, exp_err, exp_rdata); else pass_cnt++;
            total_cnt++; if (o_clean !== 1'b1) $display("FAIL rnd_quiet[%0d]: got clean=%b expected 1", it, o_clean); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_wait();
        test_round_robin();
        test_slave_error();
        test_timeout();
        test_reset_mid_data();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
